// File: rtl/asrv32_pkg.sv
// asrv32_pkg: opcodes, byte-lane masks, exit code and small datapath helpers
// shared by the ASRV32 core and the unified memory.
package asrv32_pkg;

    typedef logic [31:0] word_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam word_t INST_EBREAK = 32'h0010_0073;
    localparam word_t EXIT_CODE   = 32'h0000_005d;

    localparam logic [3:0] MASK_NONE    = 4'b0000;
    localparam logic [3:0] MASK_BYTE    = 4'b0001;
    localparam logic [3:0] MASK_HALF_LO = 4'b0011;
    localparam logic [3:0] MASK_HALF_HI = 4'b1100;
    localparam logic [3:0] MASK_WORD    = 4'b1111;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Byte-lane enables for SB/SH/SW at a given byte offset.
    function automatic logic [3:0] store_mask(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] m;
        case (f3[1:0])
            2'b00:   m = MASK_BYTE << off;
            2'b01:   m = off[1] ? MASK_HALF_HI : MASK_HALF_LO;
            2'b10:   m = MASK_WORD;
            default: m = MASK_NONE;
        endcase
        return m;
    endfunction

    // Replace only the enabled byte lanes of old_w with new_w.
    function automatic word_t merge_lanes(input word_t old_w, input word_t new_w, input logic [3:0] mask);
        word_t r;
        for (int k = 0; k < 4; k++) begin
            r[8*k +: 8] = mask[k] ? new_w[8*k +: 8] : old_w[8*k +: 8];
        end
        return r;
    endfunction

    // Pick the addressed byte/halfword out of a full word and extend it.
    function automatic word_t load_extract(input logic [2:0] f3, input logic [1:0] off, input word_t w);
        word_t s;
        word_t r;
        s = w >> {off, 3'b000};
        case (f3)
            F3_B:    r = {{24{s[7]}}, s[7:0]};
            F3_H:    r = {{16{s[15]}}, s[15:0]};
            F3_BU:   r = {24'h00_0000, s[7:0]};
            F3_HU:   r = {16'h0000, s[15:0]};
            default: r = w;
        endcase
        return r;
    endfunction

    // Integer ALU shared by OP and OP-IMM; alt selects SUB/SRA.
    function automatic word_t alu(input logic [2:0] f3, input logic alt, input word_t a, input word_t b);
        word_t r;
        case (f3)
            3'b000:  r = alt ? (a - b) : (a + b);
            3'b001:  r = a << b[4:0];
            3'b010:  r = {31'h0, $signed(a) < $signed(b)};
            3'b011:  r = {31'h0, a < b};
            3'b100:  r = a ^ b;
            3'b101:  r = alt ? word_t'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
            3'b110:  r = a | b;
            3'b111:  r = a & b;
            default: r = a + b;
        endcase
        return r;
    endfunction

    // Conditional branch decision.
    function automatic logic branch_taken(input logic [2:0] f3, input word_t a, input word_t b);
        logic t;
        case (f3)
            3'b000:  t = (a == b);
            3'b001:  t = (a != b);
            3'b100:  t = ($signed(a) < $signed(b));
            3'b101:  t = ($signed(a) >= $signed(b));
            3'b110:  t = (a < b);
            3'b111:  t = (a >= b);
            default: t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/asrv32_core.sv
// asrv32_core: compact multi-cycle RV32I core (fetch, latch, execute, memory)
// with its 32-entry register file; halts on EBREAK.
module asrv32_regfile (
    input  logic        clk,
    input  logic        i_ce_wr,
    input  logic [4:0]  i_rd_addr,
    input  logic [31:0] i_rd_data,
    input  logic [4:0]  i_rs1_addr,
    input  logic [4:0]  i_rs2_addr,
    output logic [31:0] o_rs1_data,
    output logic [31:0] o_rs2_data
);
    logic [31:0] base_regfile [0:31];

    // Register write; x0 is never written.
    always_ff @(posedge clk) begin
        if (i_ce_wr && (i_rd_addr != 5'd0)) begin
            base_regfile[i_rd_addr] <= i_rd_data;
        end
    end

    assign o_rs1_data = (i_rs1_addr == 5'd0) ? 32'h0 : base_regfile[i_rs1_addr];
    assign o_rs2_data = (i_rs2_addr == 5'd0) ? 32'h0 : base_regfile[i_rs2_addr];
endmodule

module asrv32_core
    import asrv32_pkg::*;
#(
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] o_iaddr,
    input  logic [31:0] i_inst,
    output logic [31:0] o_data_addr,
    output logic [31:0] o_data_out,
    output logic [3:0]  o_wr_mask,
    output logic        o_wr_en,
    output logic        o_rd_en,
    output logic        o_stb,
    input  logic [31:0] i_data_in,
    input  logic        i_ack
);
    localparam logic [2:0] S_FETCH = 3'd0;
    localparam logic [2:0] S_LATCH = 3'd1;
    localparam logic [2:0] S_EXEC  = 3'd2;
    localparam logic [2:0] S_MEM   = 3'd3;
    localparam logic [2:0] S_HALT  = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d, inst_q, inst_d, addr_q, addr_d, wdata_q, wdata_d;
    logic [3:0]  mask_q, mask_d;
    logic        wr_en_q, wr_en_d, rd_en_q, rd_en_d, stb_q, stb_d;

    logic [6:0]  opcode_s;
    logic [2:0]  funct3_s;
    logic [4:0]  rd_s, rs1_s, rs2_s;
    logic [31:0] imm_i_s, imm_s_s, imm_b_s, imm_u_s, imm_j_s;
    logic [31:0] rs1_data_s, rs2_data_s, alu_b_s, pc_next_s, ea_s;
    logic        alu_alt_s, rf_we_s;
    logic [31:0] rf_wdata_s;

    assign opcode_s  = inst_q[6:0];
    assign rd_s      = inst_q[11:7];
    assign funct3_s  = inst_q[14:12];
    assign rs1_s     = inst_q[19:15];
    assign rs2_s     = inst_q[24:20];
    assign imm_i_s   = {{20{inst_q[31]}}, inst_q[31:20]};
    assign imm_s_s   = {{20{inst_q[31]}}, inst_q[31:25], inst_q[11:7]};
    assign imm_b_s   = {{19{inst_q[31]}}, inst_q[31], inst_q[7], inst_q[30:25], inst_q[11:8], 1'b0};
    assign imm_u_s   = {inst_q[31:12], 12'h000};
    assign imm_j_s   = {{11{inst_q[31]}}, inst_q[31], inst_q[19:12], inst_q[20], inst_q[30:21], 1'b0};
    assign alu_b_s   = (opcode_s == OPC_OP) ? rs2_data_s : imm_i_s;
    assign alu_alt_s = inst_q[30] && ((opcode_s == OPC_OP) || (funct3_s == 3'b101));
    assign pc_next_s = pc_q + 32'd4;
    assign ea_s      = rs1_data_s + ((opcode_s == OPC_STORE) ? imm_s_s : imm_i_s);

    asrv32_regfile m0 (
        .clk       (clk),
        .i_ce_wr   (rf_we_s),
        .i_rd_addr (rd_s),
        .i_rd_data (rf_wdata_s),
        .i_rs1_addr(rs1_s),
        .i_rs2_addr(rs2_s),
        .o_rs1_data(rs1_data_s),
        .o_rs2_data(rs2_data_s)
    );

    // Sequencer: fetch, latch instruction, execute, optional memory wait.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        inst_d     = inst_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        mask_d     = mask_q;
        wr_en_d    = 1'b0;
        rd_en_d    = 1'b0;
        stb_d      = 1'b0;
        rf_we_s    = 1'b0;
        rf_wdata_s = 32'h0;
        case (state_q)
            S_FETCH: state_d = S_LATCH;
            S_LATCH: begin
                inst_d  = i_inst;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_FETCH;
                pc_d    = pc_next_s;
                case (opcode_s)
                    OPC_LUI: begin
                        rf_we_s    = 1'b1;
                        rf_wdata_s = imm_u_s;
                    end
                    OPC_AUIPC: begin
                        rf_we_s    = 1'b1;
                        rf_wdata_s = pc_q + imm_u_s;
                    end
                    OPC_JAL: begin
                        rf_we_s    = 1'b1;
                        rf_wdata_s = pc_next_s;
                        pc_d       = pc_q + imm_j_s;
                    end
                    OPC_JALR: begin
                        rf_we_s    = 1'b1;
                        rf_wdata_s = pc_next_s;
                        pc_d       = (rs1_data_s + imm_i_s) & 32'hFFFF_FFFE;
                    end
                    OPC_BRANCH: begin
                        if (branch_taken(funct3_s, rs1_data_s, rs2_data_s)) begin
                            pc_d = pc_q + imm_b_s;
                        end else begin
                            pc_d = pc_next_s;
                        end
                    end
                    OPC_LOAD: begin
                        pc_d    = pc_q;
                        addr_d  = ea_s;
                        rd_en_d = 1'b1;
                        stb_d   = 1'b1;
                        state_d = S_MEM;
                    end
                    OPC_STORE: begin
                        pc_d    = pc_q;
                        addr_d  = ea_s;
                        wdata_d = rs2_data_s << {ea_s[1:0], 3'b000};
                        mask_d  = store_mask(funct3_s, ea_s[1:0]);
                        wr_en_d = 1'b1;
                        stb_d   = 1'b1;
                        state_d = S_MEM;
                    end
                    OPC_OPIMM, OPC_OP: begin
                        rf_we_s    = 1'b1;
                        rf_wdata_s = alu(funct3_s, alu_alt_s, rs1_data_s, alu_b_s);
                    end
                    OPC_SYSTEM: begin
                        if (inst_q == INST_EBREAK) begin
                            pc_d    = pc_q;
                            state_d = S_HALT;
                        end else begin
                            pc_d = pc_next_s;
                        end
                    end
                    default: pc_d = pc_next_s;
                endcase
            end
            S_MEM: begin
                if (i_ack) begin
                    state_d = S_FETCH;
                    pc_d    = pc_next_s;
                    if (opcode_s == OPC_LOAD) begin
                        rf_we_s    = 1'b1;
                        rf_wdata_s = load_extract(funct3_s, addr_q[1:0], i_data_in);
                    end else begin
                        rf_we_s = 1'b0;
                    end
                end else begin
                    state_d = S_MEM;
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    // Core state registers; reset reloads PC_RESET and flushes the pipeline.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            pc_q    <= PC_RESET;
            inst_q  <= 32'h0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            mask_q  <= 4'b0000;
            wr_en_q <= 1'b0;
            rd_en_q <= 1'b0;
            stb_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            mask_q  <= mask_d;
            wr_en_q <= wr_en_d;
            rd_en_q <= rd_en_d;
            stb_q   <= stb_d;
        end
    end

    assign o_iaddr     = pc_q;
    assign o_data_addr = addr_q;
    assign o_data_out  = wdata_q;
    assign o_wr_mask   = mask_q;
    assign o_wr_en     = wr_en_q;
    assign o_rd_en     = rd_en_q;
    assign o_stb       = stb_q;

endmodule

// File: rtl/asrv32_unified_mem.sv
// asrv32_unified_mem: byte-addressed instruction+data memory with a registered
// instruction port and a registered, strobe/ack data port. Contents survive reset.
module asrv32_unified_mem
    import asrv32_pkg::*;
#(
    parameter int unsigned MEMORY_DEPTH = 32'd1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] iaddr,
    output logic [31:0] o_inst_out,
    input  logic [31:0] i_data_addr,
    input  logic [31:0] i_data_in,
    input  logic [3:0]  i_wr_mask,
    input  logic        i_wr_en,
    input  logic        i_rd_en,
    input  logic        i_stb,
    output logic [31:0] o_data_out,
    output logic        o_ack
);
    localparam int unsigned WORDS = MEMORY_DEPTH / 32'd4;
    localparam int unsigned AW    = (WORDS > 32'd1) ? $clog2(WORDS) : 32'd1;

    logic [31:0]   memory_regfile [0:WORDS-1];

    logic          inst_in_range_s;
    logic          data_in_range_s;
    logic [AW-1:0] inst_idx_s;
    logic [AW-1:0] data_idx_s;
    logic [31:0]   inst_out_q, inst_out_d;
    logic [31:0]   data_out_q, data_out_d;
    logic          ack_q, ack_d;

    assign inst_in_range_s = (iaddr >> 2) < 32'(WORDS);
    assign data_in_range_s = (i_data_addr >> 2) < 32'(WORDS);
    assign inst_idx_s      = iaddr[AW+1:2];
    assign data_idx_s      = i_data_addr[AW+1:2];

    // Next values of the registered read ports and the one-cycle acknowledge.
    always_comb begin
        inst_out_d = inst_in_range_s ? memory_regfile[inst_idx_s] : 32'h0;
        if (i_stb && i_rd_en) begin
            data_out_d = data_in_range_s ? memory_regfile[data_idx_s] : 32'h0;
        end else begin
            data_out_d = data_out_q;
        end
        ack_d = i_stb;
    end

    // Output registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inst_out_q <= 32'h0;
            data_out_q <= 32'h0;
            ack_q      <= 1'b0;
        end else begin
            inst_out_q <= inst_out_d;
            data_out_q <= data_out_d;
            ack_q      <= ack_d;
        end
    end

    // Byte-masked write; a reset edge drops the store, out-of-range is ignored.
    always_ff @(posedge clk) begin
        if (rst_n && i_wr_en && data_in_range_s) begin
            memory_regfile[data_idx_s] <= merge_lanes(memory_regfile[data_idx_s], i_data_in, i_wr_mask);
        end
    end

    assign o_inst_out = inst_out_q;
    assign o_data_out = data_out_q;
    assign o_ack      = ack_q;

endmodule

// File: rtl/asrv32_soc.sv
// asrv32_soc: ASRV32 core (m0) wired to the unified instruction/data memory (m1).
module asrv32_soc
    import asrv32_pkg::*;
#(
    parameter logic [31:0] PC_RESET     = 32'h0000_0000,
    parameter int unsigned MEMORY_DEPTH = 32'd1024
) (
    input logic clk,
    input logic rst_n
);
    logic [31:0] iaddr;
    logic [31:0] inst_s;
    logic [31:0] data_addr_s;
    logic [31:0] wdata_s;
    logic [31:0] rdata_s;
    logic [3:0]  wr_mask_s;
    logic        wr_en_s;
    logic        rd_en_s;
    logic        stb_s;
    logic        ack_s;

    asrv32_core #(.PC_RESET(PC_RESET)) m0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .o_iaddr    (iaddr),
        .i_inst     (inst_s),
        .o_data_addr(data_addr_s),
        .o_data_out (wdata_s),
        .o_wr_mask  (wr_mask_s),
        .o_wr_en    (wr_en_s),
        .o_rd_en    (rd_en_s),
        .o_stb      (stb_s),
        .i_data_in  (rdata_s),
        .i_ack      (ack_s)
    );

    asrv32_unified_mem #(.MEMORY_DEPTH(MEMORY_DEPTH)) m1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .iaddr      (iaddr),
        .o_inst_out (inst_s),
        .i_data_addr(data_addr_s),
        .i_data_in  (wdata_s),
        .i_wr_mask  (wr_mask_s),
        .i_wr_en    (wr_en_s),
        .i_rd_en    (rd_en_s),
        .i_stb      (stb_s),
        .o_data_out (rdata_s),
        .o_ack      (ack_s)
    );

endmodule

// File: tb/tb_asrv32_soc.sv
// Bench for asrv32_soc: directed programs preloaded into memory, register and
// memory results compared against hand-computed values.
module tb_asrv32_soc;
    import asrv32_pkg::*;

    localparam int DEPTH = 8192;
    localparam int WORDS = DEPTH / 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    asrv32_soc #(.PC_RESET(32'h0000_0000), .MEMORY_DEPTH(DEPTH)) dut  (.clk(clk), .rst_n(rst_n));
    asrv32_soc #(.PC_RESET(32'h0000_0100), .MEMORY_DEPTH(1024))  dut2 (.clk(clk), .rst_n(rst_n));

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] prog [0:31];
    int          prog_len;

    typedef struct {
        string       name;
        bit          is_mem;
        int          idx;
        logic [31:0] exp;
    } chk_t;
    chk_t tbl [0:12];

    // Logs of register-file writes, data-port writes and acknowledges.
    logic [4:0]  rf_addr_log [0:15];
    logic [31:0] rf_data_log [0:15];
    logic [3:0]  st_mask_log [0:15];
    logic [31:0] st_addr_log [0:15];
    logic [31:0] st_data_log [0:15];
    int rf_n = 0;
    int st_n = 0;
    int ack_n = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            rf_n  <= 0;
            st_n  <= 0;
            ack_n <= 0;
        end else begin
            if (dut.m0.m0.i_ce_wr && dut.m0.m0.i_rd_addr != 5'd0 && rf_n < 16) begin
                rf_addr_log[rf_n] <= dut.m0.m0.i_rd_addr;
                rf_data_log[rf_n] <= dut.m0.m0.i_rd_data;
                rf_n <= rf_n + 1;
            end
            if (dut.m1.i_wr_en && st_n < 16) begin
                st_mask_log[st_n] <= dut.m1.i_wr_mask;
                st_addr_log[st_n] <= dut.m1.i_data_addr;
                st_data_log[st_n] <= dut.m1.i_data_in;
                st_n <= st_n + 1;
            end
            if (dut.m1.o_ack) ack_n <= ack_n + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input logic [6:0] op, input int rd, input int f3, input int rs1, input int imm);
        logic [31:0] t;
        t = imm;
        return {t[11:0], 5'(rs1), 3'(f3), 5'(rd), op};
    endfunction

    function automatic logic [31:0] enc_s(input int f3, input int rs1, input int rs2, input int imm);
        logic [31:0] t;
        t = imm;
        return {t[11:5], 5'(rs2), 5'(rs1), 3'(f3), t[4:0], OPC_STORE};
    endfunction

    function automatic logic [31:0] enc_b(input int f3, input int rs1, input int rs2, input int imm);
        logic [31:0] t;
        t = imm;
        return {t[12], t[10:5], 5'(rs2), 5'(rs1), 3'(f3), t[4:1], t[11], OPC_BRANCH};
    endfunction

    function automatic logic [31:0] enc_u(input logic [6:0] op, input int rd, input int imm20);
        logic [31:0] t;
        t = imm20;
        return {t[19:0], 5'(rd), op};
    endfunction

    function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
        return enc_i(OPC_OPIMM, rd, 0, rs1, imm);
    endfunction

    task automatic set_prog_arith();
        prog[0] = addi(1, 0, 5);
        prog[1] = addi(2, 1, 7);
        prog[2] = INST_EBREAK;
        prog_len = 3;
    endtask

    task automatic set_prog_mem();
        prog[0]  = enc_u(OPC_LUI, 1, 32'h1);
        prog[1]  = addi(1, 1, 32'h80);
        prog[2]  = enc_u(OPC_LUI, 2, 32'hAABBD);
        prog[3]  = addi(2, 2, -803);
        prog[4]  = enc_s(2, 1, 2, 0);
        prog[5]  = enc_s(0, 1, 0, 1);
        prog[6]  = enc_i(OPC_LOAD, 3, 2, 1, 0);
        prog[7]  = enc_u(OPC_LUI, 4, 32'h80000);
        prog[8]  = addi(4, 4, 32'hFF);
        prog[9]  = enc_s(2, 1, 4, 0);
        prog[10] = enc_i(OPC_LOAD, 5, 0, 1, 0);
        prog[11] = enc_i(OPC_LOAD, 6, 4, 1, 0);
        prog[12] = enc_i(OPC_LOAD, 7, 1, 1, 2);
        prog[13] = enc_i(OPC_LOAD, 8, 5, 1, 2);
        prog[14] = enc_u(OPC_LUI, 9, 32'h2);
        prog[15] = enc_s(2, 9, 2, 4);
        prog[16] = addi(11, 0, -1);
        prog[17] = enc_i(OPC_LOAD, 11, 2, 9, 4);
        prog[18] = addi(12, 0, 1);
        prog[19] = INST_EBREAK;
        prog_len = 20;
    endtask

    task automatic set_prog_rvtest(input bit fail3);
        prog[0]  = addi(5, 0, 3);
        prog[1]  = addi(6, 0, 3);
        prog[2]  = addi(3, 0, 2);
        prog[3]  = enc_b(1, 5, 6, 32'h20);
        prog[4]  = addi(5, 0, 10);
        prog[5]  = addi(6, 0, fail3 ? 11 : 10);
        prog[6]  = addi(3, 0, 3);
        prog[7]  = enc_b(1, 5, 6, 32'h10);
        prog[8]  = addi(17, 0, 32'h5d);
        prog[9]  = addi(10, 0, 0);
        prog[10] = INST_EBREAK;
        prog[11] = addi(17, 0, 32'h5d);
        prog[12] = enc_i(OPC_OPIMM, 10, 1, 3, 1);
        prog[13] = enc_i(OPC_OPIMM, 10, 6, 10, 1);
        prog[14] = INST_EBREAK;
        prog_len = 15;
    endtask

    task automatic set_prog_store_reset();
        prog[0] = enc_u(OPC_LUI, 1, 32'h1);
        prog[1] = addi(2, 0, 32'h55);
        prog[2] = enc_s(2, 1, 2, 0);
        prog[3] = INST_EBREAK;
        prog_len = 4;
    endtask

    task automatic load_prog();
        for (int i = 0; i < WORDS; i++) dut.m1.memory_regfile[i] = 32'h0;
        for (int i = 0; i < prog_len; i++) dut.m1.memory_regfile[i] = prog[i];
    endtask

    // Hold reset while loading, then release #1 after an edge.
    task automatic restart();
        rst_n = 1'b0;
        @(posedge clk);
        load_prog();
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic run_until_halt(input string name);
        int  cyc;
        bit  done;
        cyc  = 0;
        done = 1'b0;
        while (!done) begin
            @(posedge clk);
            #1;
            cyc++;
            if (dut.m0.inst_q === INST_EBREAK) done = 1'b1;
            else if (dut.iaddr >= 32'(DEPTH - 4)) done = 1'b1;
            else if (cyc > 3000) done = 1'b1;
        end
        check({name, "_pc_bound"}, {31'h0, dut.iaddr < 32'(DEPTH - 4)}, 32'h1);
        check({name, "_halt"}, dut.m0.inst_q, INST_EBREAK);
    endtask

    initial begin
        logic [31:0] act;
        bit          seen;

        set_prog_mem();
        tbl[0]  = '{"x1_base",    1'b0, 1,  32'h0000_1080};
        tbl[1]  = '{"x2_data",    1'b0, 2,  32'hAABB_CCDD};
        tbl[2]  = '{"x3_sw_sb",   1'b0, 3,  32'hAABB_00DD};
        tbl[3]  = '{"x4_data",    1'b0, 4,  32'h8000_00FF};
        tbl[4]  = '{"x5_lb",      1'b0, 5,  32'hFFFF_FFFF};
        tbl[5]  = '{"x6_lbu",     1'b0, 6,  32'h0000_00FF};
        tbl[6]  = '{"x7_lh",      1'b0, 7,  32'hFFFF_8000};
        tbl[7]  = '{"x8_lhu",     1'b0, 8,  32'h0000_8000};
        tbl[8]  = '{"x9_oob",     1'b0, 9,  32'h0000_2000};
        tbl[9]  = '{"x11_oob_ld", 1'b0, 11, 32'h0000_0000};
        tbl[10] = '{"x12_cont",   1'b0, 12, 32'h0000_0001};
        tbl[11] = '{"mem_1080",   1'b1, 32'h420, 32'h8000_00FF};
        tbl[12] = '{"mem_wrap",   1'b1, 1,  addi(1, 1, 32'h80)};

        // Reset state and first fetch.
        set_prog_arith();
        rst_n = 1'b0;
        @(posedge clk);
        load_prog();
        for (int i = 0; i < 256; i++) dut2.m1.memory_regfile[i] = 32'h0;
        dut2.m1.memory_regfile[64] = INST_EBREAK;
        repeat (5) @(posedge clk);
        #1;
        check("rst_iaddr", dut.iaddr, 32'h0);
        check("rst_inst_out", dut.m1.o_inst_out, 32'h0);
        check("rst_data_out", dut.m1.o_data_out, 32'h0);
        check("rst_ack", {31'h0, dut.m1.o_ack}, 32'h0);
        check("rst_iaddr_pc100", dut2.iaddr, 32'h0000_0100);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("fetch_iaddr", dut.iaddr, 32'h0);
        check("fetch_iaddr_pc100", dut2.iaddr, 32'h0000_0100);
        @(posedge clk);
        #1;
        check("first_inst", dut.m0.inst_q, prog[0]);
        check("first_inst_pc100", dut2.m0.inst_q, INST_EBREAK);

        // Arithmetic program.
        run_until_halt("arith");
        check("arith_nwr", 32'(rf_n), 32'd2);
        check("arith_wr0_addr", {27'h0, rf_addr_log[0]}, 32'd1);
        check("arith_wr0_data", rf_data_log[0], 32'h5);
        check("arith_wr1_addr", {27'h0, rf_addr_log[1]}, 32'd2);
        check("arith_wr1_data", rf_data_log[1], 32'hc);

        // Stores, loads and out-of-range accesses, checked from the table.
        set_prog_mem();
        restart();
        run_until_halt("mem");
        for (int i = 0; i < 13; i++) begin
            if (tbl[i].is_mem) act = dut.m1.memory_regfile[tbl[i].idx];
            else               act = dut.m0.m0.base_regfile[tbl[i].idx];
            check(tbl[i].name, act, tbl[i].exp);
        end
        check("st_count", 32'(st_n), 32'd4);
        check("st0_mask", {28'h0, st_mask_log[0]}, 32'hF);
        check("st0_data", st_data_log[0], 32'hAABB_CCDD);
        check("st1_mask", {28'h0, st_mask_log[1]}, 32'h2);
        check("st1_addr", st_addr_log[1], 32'h0000_1081);
        check("st3_addr", st_addr_log[3], 32'h0000_2004);
        check("ack_count", 32'(ack_n), 32'd10);

        // riscv-tests style pass and fail-at-test-3.
        set_prog_rvtest(1'b0);
        restart();
        run_until_halt("rv_pass");
        check("rv_pass_x17", dut.m0.m0.base_regfile[17], EXIT_CODE);
        check("rv_pass_x10", dut.m0.m0.base_regfile[10], 32'h0);
        set_prog_rvtest(1'b1);
        restart();
        run_until_halt("rv_fail");
        check("rv_fail_x17", dut.m0.m0.base_regfile[17], EXIT_CODE);
        check("rv_fail_x10", dut.m0.m0.base_regfile[10], 32'h7);

        // Reset in the middle of a store drops it.
        set_prog_store_reset();
        rst_n = 1'b0;
        @(posedge clk);
        load_prog();
        dut.m1.memory_regfile[32'h400] = 32'h1234_5678;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 50 && !seen; c++) begin
            @(posedge clk);
            #1;
            if (dut.m1.i_wr_en) seen = 1'b1;
        end
        check("store_seen", {31'h0, seen}, 32'h1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("store_dropped", dut.m1.memory_regfile[32'h400], 32'h1234_5678);
        check("mid_rst_ack", {31'h0, dut.m1.o_ack}, 32'h0);
        check("mid_rst_iaddr", dut.iaddr, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
